// File: rtl/digit_serial_subtractor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | digit_serial_subtractor_if : operand/result handshake bundle          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface digit_serial_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, zero, ovf
   );
endinterface
`default_nettype wire

// File: rtl/digit_serial_subtractor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | digit_serial_subtractor : A - B - BIN, DIGIT bits per clock, with a   |
// | registered borrow chain; results held until the consumer takes them. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module digit_serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   digit_serial_subtractor_if.slave bus
);
   localparam int c_N  = WIDTH / DIGIT;
   localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_br;
   logic             r_rdy;
   logic [c_CW-1:0]  r_cnt;
   logic [DIGIT-1:0] w_a_dig;
   logic [DIGIT-1:0] w_b_dig;
   logic [DIGIT-1:0] w_d_dig;
   logic             w_br;
   logic             w_accept;
   logic             w_done;

   // r_rdy keeps in_ready low for the cycle right after a reset edge
   assign w_accept = (r_state == S_IDLE) & r_rdy & bus.in_valid;
   assign w_done   = (r_state == S_DONE);

   always_comb begin
      w_a_dig = r_a[int'(r_cnt)*DIGIT +: DIGIT];
      w_b_dig = r_b[int'(r_cnt)*DIGIT +: DIGIT];
      w_d_dig = '0;
      w_br    = r_br;
      for (int i = 0; i < DIGIT; i++) begin
         w_d_dig[i] = w_a_dig[i] ^ w_b_dig[i] ^ w_br;
         w_br       = (~w_a_dig[i] & w_b_dig[i]) | (~w_a_dig[i] & w_br) | (w_b_dig[i] & w_br);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == c_LAST) w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_rdy   <= 1'b0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_diff  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rdy   <= 1'b1;
         if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_br  <= bus.bin;
            r_cnt <= '0;
         end else if (r_state == S_BUSY) begin
            r_diff[int'(r_cnt)*DIGIT +: DIGIT] <= w_d_dig;
            r_br  <= w_br;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Outputs are forced to zero outside DONE so a partial result never shows
   assign bus.in_ready  = (r_state == S_IDLE) & r_rdy;
   assign bus.out_valid = w_done;
   assign bus.diff      = w_done ? r_diff : '0;
   assign bus.bout      = w_done & r_br;
   assign bus.zero      = w_done & (r_diff == '0);
   assign bus.ovf       = w_done & (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_diff[WIDTH-1] ^ r_a[WIDTH-1]);
endmodule
`default_nettype wire
